// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: memory wait, branch flush, load-use bubble
// Optional stall-cycle counter built only when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        r,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_r,
    output logic        idex_r,
    output logic        stall,
    output logic        mem_timeout,
    output logic [31:0] stall_count
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_inc;
    logic            load_use;
    logic            mem_stall;
    logic            mem_hold;

    assign load_use  = ex_memread && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mem_stall = mem_req && !mem_ready;
    // Once waiting, only mem_ready releases the pipeline, whatever mem_req does.
    assign mem_hold  = (state == RUN) ? mem_stall : !mem_ready;

    always_ff @(posedge clk) begin
        if (r) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_stall) state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ready) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        ifid_r   = 1'b0;
        idex_r   = 1'b0;
        if (r) begin
            ifid_r = 1'b1;
            idex_r = 1'b1;
        end else if (mem_hold) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_r = 1'b1;
            idex_r = 1'b1;
        end else if (load_use) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_r  = 1'b1;
        end
    end

    assign stall    = !pc_en;
    assign wait_inc = (wait_cnt == {TO_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (r) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (state == RUN) begin
            if (mem_stall) wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_inc;
            if (wait_inc == TO_W'(TIMEOUT)) mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (r) begin
            stall_count <= 32'h0;
        end else if (stall) begin
            stall_count <= stall_count + 32'h1;
        end
    end
`else
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        r = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rt = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_r, idex_r, stall, mem_timeout;
    logic [31:0] stall_count;
    logic [6:0]  outs;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_sc = 32'h0;

    localparam logic [6:0] O_RESET = 7'b1111_110;
    localparam logic [6:0] O_NORM  = 7'b1111_000;
    localparam logic [6:0] O_LU    = 7'b0011_011;
    localparam logic [6:0] O_BR    = 7'b1111_110;
    localparam logic [6:0] O_MEM   = 7'b0000_001;

    hazard_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .r(r), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .ifid_r(ifid_r), .idex_r(idex_r),
        .stall(stall), .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, ifid_r, idex_r, stall};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 0; ex_memread = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        r = 1; idle_inputs();
        step(); step();
        n_cmp++; if (outs !== O_RESET) begin n_bad++; $display("FAIL reset_outs: got %b exp %b", outs, O_RESET); end
        n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b exp 0", mem_timeout); end
        n_cmp++; if (stall_count !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %0d exp 0", stall_count); end
        r = 0; #1;
        n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL normal: got %b exp %b", outs, O_NORM); end
        step();
    endtask

    task automatic test_load_use();
        ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5; #1;
        n_cmp++; if (outs !== O_LU) begin n_bad++; $display("FAIL load_use_rs: got %b exp %b", outs, O_LU); end
        step(); if (CNT_EN) exp_sc++;
        idle_inputs(); #1;
        n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL after_load_use: got %b exp %b", outs, O_NORM); end
        n_cmp++; if (stall_count !== exp_sc) begin n_bad++; $display("FAIL load_use_count: got %0d exp %0d", stall_count, exp_sc); end
        ex_memread = 1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1; id_rs = 5'd3; #1;
        n_cmp++; if (outs !== O_LU) begin n_bad++; $display("FAIL load_use_rt: got %b exp %b", outs, O_LU); end
        step(); if (CNT_EN) exp_sc++;
        idle_inputs();
    endtask

    task automatic test_no_hazard();
        ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; #1;
        n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL load_r0: got %b exp %b", outs, O_NORM); end
        ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 0; id_rs = 5'd3; #1;
        n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL unused_rt: got %b exp %b", outs, O_NORM); end
        step(); idle_inputs();
    endtask

    task automatic test_branch();
        ex_branch_taken = 1; ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5; #1;
        n_cmp++; if (outs !== O_BR) begin n_bad++; $display("FAIL branch_over_lu: got %b exp %b", outs, O_BR); end
        step(); idle_inputs(); #1;
        n_cmp++; if (stall_count !== exp_sc) begin n_bad++; $display("FAIL branch_count: got %0d exp %0d", stall_count, exp_sc); end
    endtask

    task automatic test_mem_wait();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (outs !== O_MEM) begin n_bad++; $display("FAIL mem_wait_%0d: got %b exp %b", i, outs, O_MEM); end
            step(); if (CNT_EN) exp_sc++;
        end
        mem_ready = 1; ex_branch_taken = 1; #1;
        n_cmp++; if (outs !== O_BR) begin n_bad++; $display("FAIL mem_release_branch: got %b exp %b", outs, O_BR); end
        step();
        idle_inputs(); #1;
        n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL mem_back_run: got %b exp %b", outs, O_NORM); end
        n_cmp++; if (stall_count !== exp_sc) begin n_bad++; $display("FAIL mem_count: got %0d exp %0d", stall_count, exp_sc); end
        n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL mem_no_timeout: got %b exp 0", mem_timeout); end
        step();
    endtask

    task automatic test_timeout();
        logic exp_to;
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 10; i++) begin
            step(); if (CNT_EN) exp_sc++;
            exp_to = ((i - 1) >= 4);
            n_cmp++; if (mem_timeout !== exp_to) begin n_bad++; $display("FAIL timeout_edge_%0d: got %b exp %b", i, mem_timeout, exp_to); end
        end
        n_cmp++; if (outs !== O_MEM) begin n_bad++; $display("FAIL timeout_enables: got %b exp %b", outs, O_MEM); end
        mem_ready = 1; #1;
        n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL timeout_release: got %b exp %b", outs, O_NORM); end
        step(); idle_inputs(); step();
        n_cmp++; if (mem_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b exp 1", mem_timeout); end
        n_cmp++; if (stall_count !== exp_sc) begin n_bad++; $display("FAIL timeout_count: got %0d exp %0d", stall_count, exp_sc); end
    endtask

    task automatic test_reset_in_wait();
        mem_req = 1; mem_ready = 0;
        step(); step();
        r = 1; #1;
        n_cmp++; if (outs !== O_RESET) begin n_bad++; $display("FAIL rst_wait_outs: got %b exp %b", outs, O_RESET); end
        step(); r = 0; exp_sc = 32'h0;
        mem_req = 0; mem_ready = 0; #1;
        n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL rst_wait_run: got %b exp %b", outs, O_NORM); end
        n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_wait_timeout: got %b exp 0", mem_timeout); end
        n_cmp++; if (stall_count !== exp_sc) begin n_bad++; $display("FAIL rst_wait_count: got %0d exp %0d", stall_count, exp_sc); end
        // A fresh wait must start counting from zero: 3 wait edges stay below TIMEOUT=4.
        mem_req = 1;
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_wait_cnt_cleared: got %b exp 0", mem_timeout); end
        step();
        n_cmp++; if (mem_timeout !== 1'b1) begin n_bad++; $display("FAIL rst_wait_cnt_reaches: got %b exp 1", mem_timeout); end
        idle_inputs(); mem_ready = 1; step(); mem_ready = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 200; number of MEM_WAIT cycles after which mem_timeout SHALL set.
REQ-002 Parameter TO_W, default 8; width of the wait counter, with TIMEOUT < 2^TO_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 r  input  1  reset, synchronous, active-high.
REQ-005 id_rs, id_rt  input  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rt  input  1  ID instruction reads rt.
REQ-007 ex_memread, ex_rt  input  1, 5  EX instruction is a load, and its destination register.
REQ-008 ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-009 mem_req, mem_ready  input  1 each  MEM-stage access request and its completion.
REQ-010 pc_en, ifid_en, idex_en, exmem_en  output  1 each  enables for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
REQ-011 ifid_r, idex_r  output  1 each  synchronous clears (bubble insert) for IF/ID and ID/EX.
REQ-012 stall  output  1  high when pc_en is 0.
REQ-013 mem_timeout  output  1  sticky error flag.
REQ-014 stall_count  output  32  stall-cycle counter.

Function
REQ-015 The FSM SHALL have two states, RUN and MEM_WAIT; the enable and clear outputs are combinational from the state and the inputs.
REQ-016 load_use SHALL be ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
REQ-017 mem_stall SHALL be mem_req & ~mem_ready.
REQ-018 Priority SHALL be: mem_stall or MEM_WAIT, then ex_branch_taken, then load_use, then normal.
REQ-019 Memory stall (RUN with mem_stall, or MEM_WAIT with ~mem_ready): all four enables 0, ifid_r=0, idex_r=0.
REQ-020 Branch in RUN without mem_stall: all enables 1, ifid_r=1, idex_r=1; any load_use is ignored.
REQ-021 Load-use in RUN without mem_stall or branch: pc_en=0, ifid_en=0, idex_en=1, exmem_en=1, idex_r=1, ifid_r=0 (exactly one bubble per hazard).
REQ-022 Normal: all enables 1, both clears 0.
REQ-023 Transition RUN->MEM_WAIT SHALL occur on mem_stall.
REQ-024 Transition MEM_WAIT->RUN SHALL occur on mem_ready; in that cycle outputs follow the RUN rules with mem_stall=0, so the held branch or load_use is then serviced.
REQ-025 wait_cnt SHALL clear on entering MEM_WAIT, increment each MEM_WAIT cycle, and saturate at 2^TO_W-1.
REQ-026 mem_timeout SHALL set on the edge where wait_cnt reaches TIMEOUT and hold until reset; it does not alter the enables.
REQ-027 stall SHALL equal ~pc_en.
REQ-028 Reset asserted mid-MEM_WAIT SHALL return to RUN on that edge, regardless of mem_ready.

Reset
REQ-029 On a clk edge with r=1: state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0.
REQ-030 While r=1 the outputs SHALL be pc_en=1, ifid_en=1, idex_en=1, exmem_en=1, ifid_r=1, idex_r=1, stall=0.

Configuration
REQ-031 The macro HAZARD_STALL_CNT_EN SHALL control the stall counter.
REQ-032 With HAZARD_STALL_CNT_EN defined, stall_count SHALL increment by 1 on every non-reset edge with stall=1, wrapping from 0xFFFFFFFF to 0.
REQ-033 With HAZARD_STALL_CNT_EN undefined, stall_count SHALL be tied to 32'h0, no counter logic is built, and the port remains present.

Verification
REQ-034 Load-use: ex_memread=1, ex_rt=5, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_r=1 that cycle; stall_count +1.
REQ-035 Load to r0 or unused rt: ex_rt=0, id_rs=0; or ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall, all enables 1.
REQ-036 Branch plus load_use in the same cycle -> ifid_r=1, idex_r=1, pc_en=1, stall=0.
REQ-037 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> enables 0 for 3 cycles, state returns to RUN on the 4th edge; stall_count=3; mem_timeout=0.
REQ-038 Timeout: TIMEOUT=4, mem_ready held 0 for 10 cycles -> mem_timeout=1 after the 4th MEM_WAIT edge and stays 1 after mem_ready; cleared only by r.
REQ-039 Reset in MEM_WAIT: assert r for 1 cycle during a wait -> state RUN, wait_cnt=0, stall_count=0; with the macro undefined, stall_count is 0 throughout.
